lux_int_conditioner: RTL
========================

# lux_int_conditioner

Input conditioner for the lux sensor's open-drain, active-low interrupt pin, sitting directly upstream of the lux-sensor PIO's `in_port`.
- Synchronises the raw pin, rejects glitches shorter than a programmable length, and stretches each accepted assertion to a programmable minimum width.
- Its clean, active-low `int_out` lets the PIO's falling-edge capture fire exactly once per real sensor event.
- Exposes a 4-word Avalon-MM slave for filter/stretch configuration and status.

## Interface
Parameters:
- `FILT_W`, 16: filter length / counter width.
- `STRETCH_W`, 8: stretch length / counter width.
- `FILT_RST`, 500: reset value of FILT_LEN (cycles).
- `STRETCH_RST`, 4: reset value of STRETCH_LEN (cycles).

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset. **Synchronous and active-low.**
- `sensor_int_raw`  in  1  raw sensor pin; asynchronous; active-low; idles high.
- `address`  in  2  register word select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `int_out`  out  1  conditioned interrupt, active-low, to PIO `in_port`.

## Operation
- **Synchroniser:** `s1`→`s2`, both reset to 1.
- **Glitch filter:** filtered level `f` (reset 1) and counter `fc` (reset 0).
  - When `s2 == f`: `fc` ← 0.
  - When `s2 != f` and `fc >= FILT_LEN-1`: `f` ← `s2`, `fc` ← 0.
  - Otherwise: `fc` ← `fc`+1.
  - `FILT_LEN` of 0 behaves as 1.
  - The `>=` compare means reprogramming mid-count never deadlocks.
- **Stretcher:** counter `sc` (reset 0).
  - On `f` falling 1→0: `sc` ← `STRETCH_LEN`. This reload also applies during an active stretch.
  - Otherwise, if `sc != 0`: `sc` decrements.
- **Output:** `int_out` registered.
  - `int_out` ← 0 iff `ENABLE` and (`f == 0` or `sc != 0`); else 1.
  - Reset value 1.
- **Register map** (write when `chipselect && !write_n`):
  - 0 CTRL: bit0 `ENABLE`, reset 1. Writing 0 forces `int_out` high and clears `sc`; the filter keeps running.
  - 1 FILT_LEN: `[FILT_W-1:0]`, reset `FILT_RST`.
  - 2 STRETCH_LEN: `[STRETCH_W-1:0]`, reset `STRETCH_RST`.
  - 3 STATUS, read-only apart from the count-clear described under Configuration: bit31 = `s2`, bit30 = `f`, bit29 = `sc != 0`, `[15:0]` = event count (see Configuration).
  - Unused bits read 0. Upper writedata bits are ignored.
- **Reset mid-operation:** all state returns to reset values on the next edge; `int_out` is high one cycle after `reset_n` is sampled low.

## Timing
- `readdata` is registered with 1-cycle latency, sampled from `address` each cycle regardless of `chipselect`. Reset value 0.
- Latency from `s2` first differing from `f` to `f` flipping: `FILT_LEN` cycles.
- Pin-to-`int_out` assertion latency: `FILT_LEN`+3 cycles (2 sync, filter, 1 output register).
- Deassertion latency: the same, or later if `sc` is still nonzero.
- Minimum low width on `int_out`: `max(f` low time, `STRETCH_LEN`+1) cycles.
- A register write takes effect on the cycle after the write edge.

## Configuration
- `LUX_INT_EVENT_COUNT_EN` defined:
  - 16-bit event counter increments on each `f` 1→0 while `ENABLE`=1; it saturates at 0xFFFF.
  - Any write to address 3 clears it. Clear wins over a simultaneous event (result 0).
  - Read at STATUS[15:0]; reset 0.
- Not defined: no counter logic; STATUS[15:0] reads 0 and writes to address 3 have no effect.

## Structure
- **Package `lux_int_pkg`:**
  - Register address constants (`ADDR_CTRL`=0, `ADDR_FILT`=1, `ADDR_STRETCH`=2, `ADDR_STATUS`=3).
  - CTRL/STATUS bit-index constants.
  - Default-value constants.
- **Sub-module `lux_int_glitch_filter`:** synchroniser plus filter; outputs `s2` and `f`. Stretcher, registers and counter stay in the top module.

## Test plan
- **Reset/defaults:** hold `reset_n` low 3 cycles → `int_out`=1, `readdata`=0. Then read addr 1/2 → 500 / 4 (one cycle after address).
- **Glitch reject:** FILT_LEN=10; raw low 8 cycles → `int_out` stays 1, STATUS[30]=1, count 0.
- **Accept + stretch:** FILT_LEN=10, STRETCH_LEN=20; raw low 3 cycles longer than the filter needs → `int_out` falls 13 cycles after the raw edge and stays low ≥21 cycles. Count=1 with macro, 0 without.
- **Disable:** CTRL=0 during an active `int_out` → `int_out`=1 next cycle. A later valid pulse → no assertion, count unchanged.
- **Counter boundaries** (macro on): 0xFFFF events → saturates at 0xFFFF. Addr-3 write coincident with an `f` falling edge → count reads 0.
- **Reprogram mid-count:** FILT_LEN lowered from 100 to 5 while `fc`=50 → `f` flips next cycle; `int_out` follows 1 cycle later.

Source files
------------

// File: rtl/lux_int_pkg.sv
// Shared constants for the lux-sensor interrupt conditioner: register
// addresses, CTRL/STATUS bit positions and reset defaults.
package lux_int_pkg;

    // Avalon-MM word addresses
    typedef enum logic [1:0] {
        ADDR_CTRL    = 2'd0,
        ADDR_FILT    = 2'd1,
        ADDR_STRETCH = 2'd2,
        ADDR_STATUS  = 2'd3
    } reg_addr_e;

    // CTRL bit positions
    localparam int CTRL_ENABLE_BIT = 0;

    // STATUS bit positions; the event count occupies [EVT_CNT_W-1:0]
    localparam int STATUS_S2_BIT = 31;
    localparam int STATUS_F_BIT  = 30;
    localparam int STATUS_SC_BIT = 29;
    localparam int EVT_CNT_W     = 16;

    // Reset defaults
    localparam int   FILT_LEN_DEF    = 500;
    localparam int   STRETCH_LEN_DEF = 4;
    localparam logic ENABLE_RST      = 1'b1;

endpackage

// File: rtl/lux_int_glitch_filter.sv
// Two-flop synchroniser followed by a length-programmable glitch filter.
// The filtered level only follows the synchronised pin once the pin has
// held a new level for i_filt_len consecutive cycles (0 acts as 1).
module lux_int_glitch_filter
    import lux_int_pkg::*;
#(
    parameter int FILT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_raw,
    input  logic [FILT_W-1:0] i_filt_len,
    output logic              o_s2,
    output logic              o_f
);

    logic              r_s1;
    logic              r_s2;
    logic              r_f;
    logic [FILT_W-1:0] r_fc;
    logic [FILT_W-1:0] w_thresh;

    // A length of 0 collapses onto the length-1 threshold. The >= compare
    // below lets a shortened length take effect even if fc is already past it.
    assign w_thresh = (i_filt_len == '0) ? '0 : i_filt_len - FILT_W'(1);

    // Synchronise the asynchronous pin; idle level is high
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make r_s2 take the old r_s1, giving a
        // true two-stage shift; blocking here would collapse it to one flop.
        if (!reset_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // Count how long s2 has disagreed with f and flip f once it is long enough
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_f  <= 1'b1;
            r_fc <= '0;
        end else if (r_s2 == r_f) begin
            r_fc <= '0;
        end else if (r_fc >= w_thresh) begin
            r_f  <= r_s2;
            r_fc <= '0;
        end else begin
            r_fc <= r_fc + FILT_W'(1);
        end
    end

    assign o_s2 = r_s2;
    assign o_f  = r_f;

endmodule

// File: rtl/lux_int_conditioner.sv
// Lux-sensor interrupt conditioner: synchronises and de-glitches the raw
// active-low pin, stretches each accepted assertion, and drives a clean
// active-low int_out for the PIO. Configured through a 4-word Avalon-MM slave.
// Optional feature: define LUX_INT_EVENT_COUNT_EN to add a saturating
// 16-bit event counter readable at STATUS[15:0] and cleared by writing addr 3.
module lux_int_conditioner
    import lux_int_pkg::*;
#(
    parameter int FILT_W      = 16,
    parameter int STRETCH_W   = 8,
    parameter int FILT_RST    = FILT_LEN_DEF,
    parameter int STRETCH_RST = STRETCH_LEN_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sensor_int_raw,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        int_out
);

    logic                 w_wr_en;
    logic                 r_enable;
    logic [FILT_W-1:0]    r_filt_len;
    logic [STRETCH_W-1:0] r_stretch_len;

    logic                 w_s2;
    logic                 w_f;
    logic                 r_f_q;
    logic                 w_f_fall;
    logic [STRETCH_W-1:0] r_sc;
    logic                 w_sc_active;

    logic [EVT_CNT_W-1:0] w_evt_cnt;
    logic [31:0]          w_rdata;
    logic                 w_unused_wdata;

    assign w_wr_en = chipselect & ~write_n;

    // Only the low bits of each register are stored; fold the rest away
    assign w_unused_wdata = ^writedata;

    // Configuration registers, written on the bus write edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_enable      <= ENABLE_RST;
            r_filt_len    <= FILT_W'(FILT_RST);
            r_stretch_len <= STRETCH_W'(STRETCH_RST);
        end else if (w_wr_en) begin
            case (reg_addr_e'(address))
                ADDR_CTRL:    r_enable      <= writedata[CTRL_ENABLE_BIT];
                ADDR_FILT:    r_filt_len    <= writedata[FILT_W-1:0];
                ADDR_STRETCH: r_stretch_len <= writedata[STRETCH_W-1:0];
                default:      ;
            endcase
        end
    end

    lux_int_glitch_filter #(
        .FILT_W (FILT_W)
    ) u_filter (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_raw      (sensor_int_raw),
        .i_filt_len (r_filt_len),
        .o_s2       (w_s2),
        .o_f        (w_f)
    );

    // f is compared against its previous value, so the stretch reload lands
    // on the same edge int_out first goes low and yields STRETCH_LEN+1 cycles.
    assign w_f_fall    = r_f_q & ~w_f;
    assign w_sc_active = (r_sc != '0);

    // Stretch counter: reload on every accepted assertion, drain otherwise
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_f_q <= 1'b1;
            r_sc  <= '0;
        end else begin
            r_f_q <= w_f;
            if (!r_enable) begin
                r_sc <= '0;
            end else if (w_f_fall) begin
                r_sc <= r_stretch_len;
            end else if (w_sc_active) begin
                r_sc <= r_sc - STRETCH_W'(1);
            end
        end
    end

    // Registered active-low output; held high while disabled
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            int_out <= 1'b1;
        end else begin
            int_out <= ~(r_enable & (~w_f | w_sc_active));
        end
    end

`ifdef LUX_INT_EVENT_COUNT_EN
    logic [EVT_CNT_W-1:0] r_evt_cnt;
    logic                 w_cnt_clr;

    assign w_cnt_clr = w_wr_en && (address == ADDR_STATUS);

    // Saturating event counter; a clear beats a coincident event
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_evt_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_evt_cnt <= '0;
        end else if (r_enable && w_f_fall && (r_evt_cnt != '1)) begin
            r_evt_cnt <= r_evt_cnt + EVT_CNT_W'(1);
        end
    end

    assign w_evt_cnt = r_evt_cnt;
`else
    assign w_evt_cnt = '0;
`endif

    // Read mux for the addressed word
    always_comb begin
        // NOTE: defaulting the whole word first keeps every path assigned, so
        // no latch is inferred and unused bits read as zero.
        w_rdata = '0;
        case (reg_addr_e'(address))
            ADDR_CTRL:    w_rdata[CTRL_ENABLE_BIT]  = r_enable;
            ADDR_FILT:    w_rdata[FILT_W-1:0]       = r_filt_len;
            ADDR_STRETCH: w_rdata[STRETCH_W-1:0]    = r_stretch_len;
            ADDR_STATUS: begin
                w_rdata[STATUS_S2_BIT]  = w_s2;
                w_rdata[STATUS_F_BIT]   = w_f;
                w_rdata[STATUS_SC_BIT]  = w_sc_active;
                w_rdata[EVT_CNT_W-1:0]  = w_evt_cnt;
            end
            default: ;
        endcase
    end

    // Read data is registered every cycle, independent of chipselect
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= w_rdata;
        end
    end

endmodule
